ddc_axis_feeder: RTL and testbench
==================================

Name: ddc_axis_feeder

Overview:
- Upstream stage of the DDC input path, in the axis_clk domain.
- Accepts 64-bit AXI-stream beats from the DMA; each beat carries two 32-bit sample words.
- Re-serialises them into the 32-bit AXI stream consumed by the DDC input FIFO, with optional offset-binary to two's-complement conversion.
- Regenerates output frame boundaries (tlast) and reports framing errors and frame counts to software status registers.

Parameters:
- U_DLY, 1, simulation delay on non-blocking register assignments.
- FRAME_LEN, 512, output words per frame; legal range 2..65535, even values only.
- ERR_W, 8, width of the saturating framing-error counter.

Ports:
- rst_n  input  1  asynchronous active-low reset.
- axis_clk  input  1  stream clock; all logic is synchronous to it.
- enable  input  1  run control; quasi-static, driven by a register in the axis_clk domain.
- fmt_offset_bin  input  1  1 = inverts bit 15 and bit 31 of every output word.
- s_axis_tvalid  input  1  DMA beat valid.
- s_axis_tready  output  1  DMA beat ready.
- s_axis_tdata  input  64  [31:0] is the first word, [63:32] is the second word.
- s_axis_tlast  input  1  DMA end of frame.
- m_axis_tvalid  output  1  output word valid.
- m_axis_tready  input  1  output word ready; DDC FIFO not full.
- m_axis_tdata  output  32  output sample word.
- m_axis_tlast  output  1  last word of an output frame.
- frame_cnt  output  16  completed output frames; wraps at 2^16.
- err_cnt  output  ERR_W  framing errors; saturates at all-ones.
- busy  output  1  high while a held word is not yet fully emitted.

Behaviour:
- Reset: async assert, sync release to rst_n. All of the following clear to 0: state, holding register, word counter, frame_cnt, err_cnt, and every output (s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy). A reset mid-frame drops any held word without emitting it.
- FSM has three states:
  - IDLE: s_axis_tready = enable. On an accepted s beat, latch tdata into hold[63:0] and tlast into hold_last, then go to LO.
  - LO: m_axis_tvalid = 1 and m_axis_tdata = conv(hold[31:0]). On m handshake, go to HI.
  - HI: m_axis_tvalid = 1 and m_axis_tdata = conv(hold[63:32]). s_axis_tready = enable & m_axis_tready, so a new beat can be accepted in the same cycle as the HI handshake.
    - On HI handshake with a new s beat accepted: reload hold and go to LO.
    - On HI handshake with no new beat: go to IDLE.
- Throughput: one output word per cycle sustained, with no bubble between input beats.
- Latency: an s beat accepted at cycle N produces its LO word on m_axis at cycle N+1.
- Output registers: m_axis_tdata, m_axis_tvalid and m_axis_tlast come from registers. s_axis_tready is combinational from state, enable and m_axis_tready.
- AXI rules:
  - Once m_axis_tvalid rises, it stays high and m_axis_tdata/m_axis_tlast stay stable until the handshake completes.
  - A deassertion of m_axis_tready never drops m_axis_tvalid.
- conv(): if fmt_offset_bin = 1, invert word[15] and word[31]; otherwise pass the word unchanged. It is sampled when the word is loaded onto m_axis.
- Word counter wcnt, range 0..FRAME_LEN-1, advances on each m handshake.
  - m_axis_tlast = 1 on the word where wcnt == FRAME_LEN-1, or on the HI word of a beat with hold_last = 1.
  - On a handshake with m_axis_tlast = 1: wcnt returns to 0 and frame_cnt increments.
- Framing errors: err_cnt increments (saturating) when either of these happens:
  - hold_last = 1 but the HI word is not at wcnt == FRAME_LEN-1 (early DMA tlast; the frame is resynchronised, wcnt is forced to 0);
  - wcnt reaches FRAME_LEN-1 on a HI word of a beat with hold_last = 0 (missing DMA tlast; the output tlast is still generated).
- enable deasserted mid-word: the current LO/HI words are still emitted, then the FSM parks in IDLE with s_axis_tready = 0. Counters are held, not cleared.
- busy = (state != IDLE).

Decomposition:
- Shared package ddc_pkg holds:
  - FSM state encoding (IDLE = 2'd0, LO = 2'd1, HI = 2'd2);
  - the default FRAME_LEN constant;
  - the conv bit positions (15 and 31).
- No sub-modules: the FSM, counters and conversion stay inline.
- An optional 2-entry output skid buffer (axis_skid32) may be instantiated if timing on s_axis_tready fails. It is not instantiated by default.

Test Plan:
- Continuous streaming, FRAME_LEN = 4: drive beats 0x00000002_00000001 and 0x00000004_00000003 with s_axis_tlast on the second, and m_axis_tready = 1. Required: output words 1, 2, 3, 4 on consecutive cycles; m_axis_tlast only on word 4; frame_cnt = 1; err_cnt = 0.
- Backpressure: same input, with m_axis_tready toggling 1,0,0,1 repeatedly. Required: m_axis_tdata and m_axis_tlast stay stable while stalled; no word is lost or duplicated; s_axis_tready = 0 during the LO state.
- Offset-binary conversion: fmt_offset_bin = 1 with input word 0x80008000. Required: output 0x00000000. Input word 0x7FFF0001 produces output 0xFFFF8001.
- Framing errors:
  - Early tlast on beat 1 of a FRAME_LEN = 8 frame: required err_cnt = 1, tlast on word 2, wcnt restarts at 0.
  - Next frame with no input tlast: required tlast on word 8 and err_cnt = 2.
- Error saturation: force 300 framing errors with ERR_W = 8. Required: err_cnt holds at 0xFF.
- Control and reset:
  - Deassert enable during LO: required HI is still emitted, then s_axis_tready = 0 and busy = 0.
  - Assert rst_n low during HI: required m_axis_tvalid = 0 immediately and all counters at 0.

Source files
------------

// File: rtl/ddc_pkg.sv
// Shared definitions for the DDC input feeder: FSM encoding, default frame
// length, offset-binary conversion bit positions and the 64-bit beat layout.
package ddc_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BEAT_W        = 64;
  localparam int unsigned WCNT_W        = 16;
  localparam int unsigned FCNT_W        = 16;
  localparam int unsigned FRAME_LEN_DEF = 512;
  localparam int unsigned CONV_BIT_LO   = 15;
  localparam int unsigned CONV_BIT_HI   = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } feed_state_e;

  // DMA beat: first word in the low half, second word in the high half
  typedef struct packed {
    logic [WORD_W-1:0] hi;
    logic [WORD_W-1:0] lo;
  } beat_t;

  // Offset-binary to two's-complement: flip the sign bit of each 16-bit half
  function automatic logic [WORD_W-1:0] conv(input logic [WORD_W-1:0] w,
                                             input logic              offset_bin);
    logic [WORD_W-1:0] r;
    r = w;
    if (offset_bin) begin
      r[CONV_BIT_LO] = ~w[CONV_BIT_LO];
      r[CONV_BIT_HI] = ~w[CONV_BIT_HI];
    end
    return r;
  endfunction

endpackage

// File: rtl/ddc_axis_feeder_if.sv
// AXI-stream bundle used on both sides of the feeder.
//   tvalid/tdata/tlast : master -> slave
//   tready             : slave -> master
interface ddc_axis_feeder_if #(
  parameter int unsigned DATA_W = ddc_pkg::WORD_W
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ddc_axis_feeder.sv
// DDC input feeder: splits 64-bit DMA beats into two 32-bit output words,
// optionally converts offset-binary samples, regenerates output tlast every
// FRAME_LEN words and counts completed frames and framing errors.
// Ports:
//   rst_n, axis_clk   : async active-low reset, stream clock
//   enable            : run control (quasi-static)
//   fmt_offset_bin    : 1 = flip bits 15 and 31 of each output word
//   s_axis (slave)    : 64-bit DMA beats in; tready is combinational
//   m_axis (master)   : 32-bit words out; tvalid/tdata/tlast registered
//   frame_cnt         : completed output frames, wraps
//   err_cnt           : framing errors, saturating
//   busy              : a held beat is not yet fully emitted
module ddc_axis_feeder
  import ddc_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned ERR_W     = 8
) (
  input  logic              rst_n,
  input  logic              axis_clk,
  input  logic              enable,
  input  logic              fmt_offset_bin,
  ddc_axis_feeder_if.slave  s_axis,
  ddc_axis_feeder_if.master m_axis,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              busy
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_LEN - 1);

  feed_state_e       state_q, state_d;
  logic [WORD_W-1:0] hold_hi_q, hold_hi_d;
  logic              hold_last_q, hold_last_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic [WORD_W-1:0] m_tdata_q, m_tdata_d;
  logic              m_tlast_q, m_tlast_d;
  logic              busy_q, busy_d;

  logic              s_ready_c;
  logic              s_hs;
  logic              m_hs;
  logic              err_inc;
  logic [WCNT_W-1:0] wcnt_adv;
  beat_t             beat_c;

  // Next-state, datapath and counter logic
  always_comb begin
    state_d     = state_q;
    hold_hi_d   = hold_hi_q;
    hold_last_d = hold_last_q;
    wcnt_d      = wcnt_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    s_ready_c   = 1'b0;
    err_inc     = 1'b0;
    beat_c      = beat_t'(s_axis.tdata);
    m_hs        = m_tvalid_q & m_axis.tready;
    // Word position after the current handshake; tlast always restarts the frame
    wcnt_adv    = m_tlast_q ? '0 : WCNT_W'(wcnt_q + 1'b1);

    case (state_q)
      ST_IDLE: s_ready_c = enable;
      ST_HI:   s_ready_c = enable & m_axis.tready;
      default: s_ready_c = 1'b0;
    endcase
    s_hs = s_ready_c & s_axis.tvalid;

    if (m_hs) begin
      wcnt_d = wcnt_adv;
      if (m_tlast_q) begin
        frame_cnt_d = FCNT_W'(frame_cnt_q + 1'b1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          hold_hi_d   = beat_c.hi;
          hold_last_d = s_axis.tlast;
          m_tvalid_d  = 1'b1;
          m_tdata_d   = conv(beat_c.lo, fmt_offset_bin);
          m_tlast_d   = (wcnt_d == WCNT_LAST);
          state_d     = ST_LO;
        end
      end
      ST_LO: begin
        if (m_hs) begin
          m_tdata_d = conv(hold_hi_q, fmt_offset_bin);
          m_tlast_d = hold_last_q | (wcnt_adv == WCNT_LAST);
          // Early DMA tlast, or frame end reached without DMA tlast
          err_inc   = hold_last_q ? (wcnt_adv != WCNT_LAST) : (wcnt_adv == WCNT_LAST);
          state_d   = ST_HI;
        end
      end
      ST_HI: begin
        if (m_hs) begin
          if (s_hs) begin
            hold_hi_d   = beat_c.hi;
            hold_last_d = s_axis.tlast;
            m_tdata_d   = conv(beat_c.lo, fmt_offset_bin);
            m_tlast_d   = (wcnt_d == WCNT_LAST);
            state_d     = ST_LO;
          end else begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = ERR_W'(err_cnt_q + 1'b1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_hi_q   <= '0;
      hold_last_q <= 1'b0;
      wcnt_q      <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_hi_q   <= hold_hi_d;
      hold_last_q <= hold_last_d;
      wcnt_q      <= wcnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      busy_q      <= busy_d;
    end
  end

  assign s_axis.tready = s_ready_c;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tlast  = m_tlast_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ddc_axis_feeder.sv
// Bench for ddc_axis_feeder: dut_a uses FRAME_LEN=4, dut_b FRAME_LEN=8.
// sel routes the shared stimulus to one instance and its outputs to the checks.
module tb_ddc_axis_feeder;
  import ddc_pkg::*;

  logic axis_clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic fmt_offset_bin = 1'b0;
  always #5 axis_clk = ~axis_clk;

  logic        sel = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [63:0] s_data = '0;
  logic        man_ready = 1'b0;
  logic        bp_ready = 1'b0;
  logic        bp_mode = 1'b0;
  logic        m_ready;
  assign m_ready = bp_mode ? bp_ready : man_ready;

  ddc_axis_feeder_if #(.DATA_W(64)) sa ();
  ddc_axis_feeder_if #(.DATA_W(32)) ma ();
  ddc_axis_feeder_if #(.DATA_W(64)) sb ();
  ddc_axis_feeder_if #(.DATA_W(32)) mb ();

  assign sa.tvalid = s_valid & ~sel;
  assign sa.tdata  = s_data;
  assign sa.tlast  = s_last;
  assign ma.tready = m_ready;
  assign sb.tvalid = s_valid & sel;
  assign sb.tdata  = s_data;
  assign sb.tlast  = s_last;
  assign mb.tready = m_ready;

  logic [15:0] fc_a, fc_b;
  logic [7:0]  ec_a, ec_b;
  logic        busy_a, busy_b;

  ddc_axis_feeder #(.FRAME_LEN(4), .ERR_W(8)) dut_a (
    .rst_n(rst_n), .axis_clk(axis_clk), .enable(enable), .fmt_offset_bin(fmt_offset_bin),
    .s_axis(sa), .m_axis(ma), .frame_cnt(fc_a), .err_cnt(ec_a), .busy(busy_a));

  ddc_axis_feeder #(.FRAME_LEN(8), .ERR_W(8)) dut_b (
    .rst_n(rst_n), .axis_clk(axis_clk), .enable(enable), .fmt_offset_bin(fmt_offset_bin),
    .s_axis(sb), .m_axis(mb), .frame_cnt(fc_b), .err_cnt(ec_b), .busy(busy_b));

  logic        o_sready, o_mvalid, o_mlast, o_busy;
  logic [31:0] o_mdata;
  logic [15:0] o_frame;
  logic [7:0]  o_err;
  assign o_sready = sel ? sb.tready : sa.tready;
  assign o_mvalid = sel ? mb.tvalid : ma.tvalid;
  assign o_mdata  = sel ? mb.tdata  : ma.tdata;
  assign o_mlast  = sel ? mb.tlast  : ma.tlast;
  assign o_frame  = sel ? fc_b : fc_a;
  assign o_err    = sel ? ec_b : ec_a;
  assign o_busy   = sel ? busy_b : busy_a;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Output word capture plus on-the-fly AXI stability checks
  typedef struct { logic [31:0] data; logic last; } word_exp_t;
  logic [31:0] wq[$];
  logic        lq[$];
  int          cq[$];
  word_exp_t   ex[$];
  int          cyc = 0;
  logic        bp_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_l = 1'b0;

  initial forever begin
    @(posedge axis_clk);
    cyc++;
  end

  initial forever begin
    @(negedge axis_clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(o_mvalid), 64'(1));
        chk("stall_data", 64'(o_mdata), 64'(prev_d));
        chk("stall_last", 64'(o_mlast), 64'(prev_l));
      end
      if (bp_chk && o_mvalid && (wq.size() % 2 == 0)) begin
        chk("lo_sready", 64'(o_sready), 64'(0));
      end
      if (o_mvalid && m_ready) begin
        wq.push_back(o_mdata);
        lq.push_back(o_mlast);
        cq.push_back(cyc);
      end
      prev_stall = o_mvalid && !m_ready;
      prev_d = o_mdata;
      prev_l = o_mlast;
    end
  end

  // Sink backpressure pattern 1,0,0,1 repeating
  initial begin
    logic pat [4];
    int idx;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    idx = 0;
    forever begin
      @(posedge axis_clk);
      #1;
      if (bp_mode) begin
        bp_ready = pat[idx];
        idx = (idx + 1) % 4;
      end else begin
        idx = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge axis_clk);
    #1;
  endtask

  task automatic clear_q();
    wq.delete(); lq.delete(); cq.delete(); ex.delete();
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0;
    sel = s; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    enable = 1'b0; fmt_offset_bin = 1'b0; man_ready = 1'b0; bp_mode = 1'b0;
    #2;
    step(2);
    chk("rst_mvalid", 64'(o_mvalid), 64'(0));
    chk("rst_mdata", 64'(o_mdata), 64'(0));
    chk("rst_mlast", 64'(o_mlast), 64'(0));
    chk("rst_frame", 64'(o_frame), 64'(0));
    chk("rst_err", 64'(o_err), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_sready", 64'(o_sready), 64'(0));
    rst_n = 1'b1;
    step(1);
    enable = 1'b1;
    clear_q();
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send_beat(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    forever begin
      @(negedge axis_clk);
      if (o_sready) break;
      n++;
      if (n > 200) break;
    end
    @(posedge axis_clk);
    #1;
    s_valid = 1'b0;
    if (n > 200) fail_now("send_beat");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_busy || o_mvalid) && n < 2000) begin
      step(1);
      n++;
    end
    if (n >= 2000) fail_now("wait_idle");
  endtask

  task automatic wait_words(input int cnt);
    int n;
    n = 0;
    while (wq.size() < cnt && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) fail_now("wait_words");
  endtask

  task automatic add_exp(input logic [31:0] d, input logic l);
    word_exp_t e;
    e.data = d;
    e.last = l;
    ex.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_count"}, 64'(wq.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size(); i++) begin
      if (i < wq.size()) begin
        chk($sformatf("%s_data%0d", tag, i), 64'(wq[i]), 64'(ex[i].data));
        chk($sformatf("%s_last%0d", tag, i), 64'(lq[i]), 64'(ex[i].last));
      end
    end
  endtask

  typedef struct {
    logic        fmt;
    logic [63:0] beat;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
  } conv_vec_t;
  conv_vec_t cv [5];

  initial begin
    cv[0] = '{fmt: 1'b1, beat: 64'h7FFF0001_80008000, exp_lo: 32'h00000000, exp_hi: 32'hFFFF8001};
    cv[1] = '{fmt: 1'b0, beat: 64'h7FFF0001_80008000, exp_lo: 32'h80008000, exp_hi: 32'h7FFF0001};
    cv[2] = '{fmt: 1'b1, beat: 64'hFFFFFFFF_00000000, exp_lo: 32'h80008000, exp_hi: 32'h7FFF7FFF};
    cv[3] = '{fmt: 1'b0, beat: 64'h12345678_9ABCDEF0, exp_lo: 32'h9ABCDEF0, exp_hi: 32'h12345678};
    cv[4] = '{fmt: 1'b1, beat: 64'h12345678_9ABCDEF0, exp_lo: 32'h1ABC5EF0, exp_hi: 32'h9234D678};

    // Continuous streaming, FRAME_LEN=4
    do_reset(1'b0);
    man_ready = 1'b1;
    send_beat(64'h00000002_00000001, 1'b0);
    chk("latency_valid", 64'(o_mvalid), 64'(1));
    chk("latency_data", 64'(o_mdata), 64'(1));
    send_beat(64'h00000004_00000003, 1'b1);
    wait_idle();
    add_exp(32'd1, 1'b0); add_exp(32'd2, 1'b0); add_exp(32'd3, 1'b0); add_exp(32'd4, 1'b1);
    compare_out("stream");
    for (int i = 1; i < 4; i++) begin
      if (i < cq.size()) chk($sformatf("stream_gap%0d", i), 64'(cq[i] - cq[i-1]), 64'(1));
    end
    chk("stream_frame", 64'(o_frame), 64'(1));
    chk("stream_err", 64'(o_err), 64'(0));

    // Backpressure
    do_reset(1'b0);
    bp_mode = 1'b1;
    bp_chk = 1'b1;
    send_beat(64'h00000002_00000001, 1'b0);
    send_beat(64'h00000004_00000003, 1'b1);
    wait_idle();
    bp_chk = 1'b0;
    bp_mode = 1'b0;
    add_exp(32'd1, 1'b0); add_exp(32'd2, 1'b0); add_exp(32'd3, 1'b0); add_exp(32'd4, 1'b1);
    compare_out("bp");
    chk("bp_frame", 64'(o_frame), 64'(1));
    chk("bp_err", 64'(o_err), 64'(0));

    // Offset-binary conversion table
    do_reset(1'b0);
    man_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fmt_offset_bin = cv[i].fmt;
      clear_q();
      send_beat(cv[i].beat, 1'b0);
      wait_words(2);
      if (wq.size() >= 2) begin
        chk($sformatf("conv%0d_lo", i), 64'(wq[0]), 64'(cv[i].exp_lo));
        chk($sformatf("conv%0d_hi", i), 64'(wq[1]), 64'(cv[i].exp_hi));
      end
      step(1);
    end

    // Framing errors, FRAME_LEN=8: early tlast, then missing tlast
    do_reset(1'b1);
    man_ready = 1'b1;
    send_beat(64'h00000002_00000001, 1'b1);
    wait_idle();
    add_exp(32'd1, 1'b0); add_exp(32'd2, 1'b1);
    compare_out("early");
    chk("early_err", 64'(o_err), 64'(1));
    chk("early_frame", 64'(o_frame), 64'(1));
    clear_q();
    for (int i = 0; i < 4; i++) begin
      send_beat({32'(32'h11 + 2 * i), 32'(32'h10 + 2 * i)}, 1'b0);
    end
    wait_idle();
    for (int i = 0; i < 8; i++) add_exp(32'(32'h10 + i), (i == 7));
    compare_out("missing");
    chk("missing_err", 64'(o_err), 64'(2));
    chk("missing_frame", 64'(o_frame), 64'(2));

    // Error saturation, FRAME_LEN=4: every single-beat tlast frame is early
    do_reset(1'b0);
    man_ready = 1'b1;
    for (int i = 0; i < 254; i++) send_beat(64'(i), 1'b1);
    wait_idle();
    chk("sat_254", 64'(o_err), 64'(8'hFE));
    send_beat(64'h55, 1'b1);
    wait_idle();
    chk("sat_255", 64'(o_err), 64'(8'hFF));
    for (int i = 0; i < 45; i++) send_beat(64'(i), 1'b1);
    wait_idle();
    chk("sat_300", 64'(o_err), 64'(8'hFF));
    chk("sat_frame", 64'(o_frame), 64'(300));

    // Reset asserted while a HI word is stalled on the output
    clear_q();
    man_ready = 1'b0;
    send_beat(64'hBBBBBBBB_AAAAAAAA, 1'b0);
    man_ready = 1'b1;
    step(1);
    man_ready = 1'b0;
    chk("hi_valid", 64'(o_mvalid), 64'(1));
    chk("hi_data", 64'(o_mdata), 64'(32'hBBBBBBBB));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 64'(o_mvalid), 64'(0));
    chk("arst_mdata", 64'(o_mdata), 64'(0));
    chk("arst_busy", 64'(o_busy), 64'(0));
    chk("arst_frame", 64'(o_frame), 64'(0));
    chk("arst_err", 64'(o_err), 64'(0));
    step(2);
    rst_n = 1'b1;
    step(1);

    // enable dropped while the LO word is pending
    do_reset(1'b0);
    man_ready = 1'b0;
    send_beat(64'hD2D2D2D2_C1C1C1C1, 1'b0);
    enable = 1'b0;
    s_valid = 1'b1;
    s_data = 64'hEEEEEEEE_EEEEEEEE;
    s_last = 1'b0;
    man_ready = 1'b1;
    step(6);
    add_exp(32'hC1C1C1C1, 1'b0); add_exp(32'hD2D2D2D2, 1'b0);
    compare_out("en_off");
    chk("en_off_sready", 64'(o_sready), 64'(0));
    chk("en_off_busy", 64'(o_busy), 64'(0));
    chk("en_off_mvalid", 64'(o_mvalid), 64'(0));
    s_valid = 1'b0;
    enable = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
